// File: rtl/dmem_arb_pkg.sv
// Shared types and RISC-V load/store encodings for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0]; byte accesses can never be misaligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            3'b010, 3'b110: mis = (addr_lo != 2'b00);
            3'b001, 3'b101: mis = addr_lo[0];
            default:        mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Data-memory port bundle; the arbiter drives it as master, the memory as slave.
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] mem_a;
    logic [DATA_W-1:0]     mem_wd;
    logic [2:0]            mem_funct3;
    logic [DATA_W-1:0]     mem_rd;

    modport master (
        output MemRead, MemWrite, mem_a, mem_wd, mem_funct3,
        input  mem_rd
    );

    modport slave (
        input  MemRead, MemWrite, mem_a, mem_wd, mem_funct3,
        output mem_rd
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: the first requester after 'last' wins.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant
);
    localparam int IW = $clog2(N);

    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last) + i) % N);
            if (!found && (|(req & (N'(1) << idx)))) begin
                grant = N'(1) << idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of one data-memory port between NUM_REQ requesters,
// one transaction at a time, with misaligned accesses answered by an error.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*DM_ADDRESS-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*3-1:0]          req_funct3,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic                          rerr,
    dmem_arbiter_if.master                mem
);
    localparam int IW = $clog2(NUM_REQ);

    state_t                state, next_state;
    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         last_winner, resp_idx, win_idx;
    logic                  win_we, win_mis, take;
    logic [DM_ADDRESS-1:0] win_addr;
    logic [DATA_W-1:0]     win_wdata;
    logic [2:0]            win_funct3;
    logic                  lat_we, err_flag;
    logic [DATA_W-1:0]     rdata_reg;
    logic                  mem_read_q, mem_write_q;
    logic [DM_ADDRESS-1:0] mem_a_q;
    logic [DATA_W-1:0]     mem_wd_q;
    logic [2:0]            mem_f3_q;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req),
        .last  (last_winner),
        .grant (grant)
    );

    // Pull the winning requester's fields out of the packed request buses.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_idx = IW'(i);
        end
        win_we     = |(req_we & grant);
        win_addr   = DM_ADDRESS'(req_addr >> (int'(win_idx) * DM_ADDRESS));
        win_wdata  = DATA_W'(req_wdata >> (int'(win_idx) * DATA_W));
        win_funct3 = 3'(req_funct3 >> (int'(win_idx) * 3));
        win_mis    = is_misaligned(win_funct3, win_addr[1:0]);
    end

    assign take = (state == IDLE) && (|grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (|grant) next_state = win_mis ? RESP : ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // gnt is masked during reset so a held request cannot leak a grant.
    always_comb begin
        gnt    = (state == IDLE && rst_n) ? grant : '0;
        rvalid = (state == RESP) ? (NUM_REQ'(1) << resp_idx) : '0;
        rerr   = (state == RESP) && err_flag;
    end

    // Memory strobes are loaded at grant and cleared after the single ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= IW'(NUM_REQ - 1);
            resp_idx    <= '0;
            lat_we      <= 1'b0;
            err_flag    <= 1'b0;
            rdata_reg   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_a_q     <= '0;
            mem_wd_q    <= '0;
            mem_f3_q    <= '0;
        end else if (take) begin
            last_winner <= win_idx;
            resp_idx    <= win_idx;
            lat_we      <= win_we;
            err_flag    <= win_mis;
            if (win_mis) begin
                rdata_reg <= '0;
            end else begin
                mem_read_q  <= ~win_we;
                mem_write_q <= win_we;
                mem_a_q     <= win_addr;
                mem_wd_q    <= win_wdata;
                mem_f3_q    <= win_funct3;
            end
        end else if (state == ACCESS) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rdata_reg   <= lat_we ? '0 : mem.mem_rd;
        end
    end

    assign rdata          = rdata_reg;
    assign mem.MemRead    = mem_read_q;
    assign mem.MemWrite   = mem_write_q;
    assign mem.mem_a      = mem_a_q;
    assign mem.mem_wd     = mem_wd_q;
    assign mem.mem_funct3 = mem_f3_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-array memory, transaction-level
// reference model checked every cycle, plus directed literal expectations.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_req    [N];
    logic          f_we     [N];
    logic [AW-1:0] f_addr   [N];
    logic [DW-1:0] f_wdata  [N];
    logic [2:0]    f_funct3 [N];
    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*3-1:0]  req_funct3;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            rerr;
    logic [7:0]      env_mem [512];
    logic [AW-1:0]   ra1, ra2, ra3;
    int total = 0;
    int bad = 0;

    dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) mem_bus ();

    dmem_arbiter #(.NUM_REQ(N), .DM_ADDRESS(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rerr       (rerr),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    assign req        = {f_req[1], f_req[0]};
    assign req_we     = {f_we[1], f_we[0]};
    assign req_addr   = {f_addr[1], f_addr[0]};
    assign req_wdata  = {f_wdata[1], f_wdata[0]};
    assign req_funct3 = {f_funct3[1], f_funct3[0]};

    function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Memory: combinational read, write on the falling edge.
    assign ra1 = mem_bus.mem_a + 9'd1;
    assign ra2 = mem_bus.mem_a + 9'd2;
    assign ra3 = mem_bus.mem_a + 9'd3;
    assign mem_bus.mem_rd = ld_ext(mem_bus.mem_funct3,
        {env_mem[ra3], env_mem[ra2], env_mem[ra1], env_mem[mem_bus.mem_a]});

    initial begin
        for (int i = 0; i < 512; i++) env_mem[i] = 8'h00;
        env_mem[16] = 8'hBB; env_mem[17] = 8'hAA; env_mem[18] = 8'h99; env_mem[19] = 8'h88;
        forever begin
            @(negedge clk);
            if (mem_bus.MemWrite) begin
                env_mem[mem_bus.mem_a] = mem_bus.mem_wd[7:0];
                if (mem_bus.mem_funct3[1:0] != 2'b00) env_mem[ra1] = mem_bus.mem_wd[15:8];
                if (mem_bus.mem_funct3[1:0] == 2'b10) begin
                    env_mem[ra2] = mem_bus.mem_wd[23:16];
                    env_mem[ra3] = mem_bus.mem_wd[31:24];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Reference model: one outstanding transaction described by its age in cycles.
    initial begin : model
        logic [7:0]  gold [512];
        int          m_last, w, t_idx, t_age, t_resp_age;
        bit          t_valid, t_we, t_err, acc_now;
        logic [8:0]  t_addr;
        logic [31:0] t_wd, t_data, m_rdata;
        logic [2:0]  t_f3;
        logic [1:0]  e_gnt, e_rvalid;
        logic        e_rerr, e_mr, e_mw;
        for (int i = 0; i < 512; i++) gold[i] = 8'h00;
        gold[16] = 8'hBB; gold[17] = 8'hAA; gold[18] = 8'h99; gold[19] = 8'h88;
        m_last = N - 1; t_valid = 0; m_rdata = 0; w = 0;
        t_idx = 0; t_age = 0; t_resp_age = 0; t_we = 0; t_err = 0;
        t_addr = 0; t_wd = 0; t_data = 0; t_f3 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                t_valid = 0; m_last = N - 1; m_rdata = 0;
                checkOutput("rst_gnt", 32'(gnt), 0);
                checkOutput("rst_rvalid", 32'(rvalid), 0);
                checkOutput("rst_rdata", rdata, 0);
                checkOutput("rst_memrw", {30'b0, mem_bus.MemRead, mem_bus.MemWrite}, 0);
                checkOutput("rst_mem_a", 32'(mem_bus.mem_a), 0);
                continue;
            end
            e_gnt = 0; e_rvalid = 0; e_rerr = 0; e_mr = 0; e_mw = 0;
            acc_now = t_valid && !t_err && t_age == 1;
            if (acc_now) begin
                e_mr = !t_we;
                e_mw = t_we;
            end
            if (t_valid && t_age == t_resp_age) begin
                e_rvalid = 2'(32'd1 << t_idx);
                e_rerr = t_err;
                m_rdata = t_data;
            end
            if (!t_valid && req != 0) begin
                for (int k = N; k >= 1; k--) begin
                    if (((int'(req) >> ((m_last + k) % N)) & 1) == 1) w = (m_last + k) % N;
                end
                e_gnt = 2'(32'd1 << w);
            end
            checkOutput("gnt", 32'(gnt), 32'(e_gnt));
            checkOutput("rvalid", 32'(rvalid), 32'(e_rvalid));
            checkOutput("rerr", 32'(rerr), 32'(e_rerr));
            checkOutput("rdata", rdata, m_rdata);
            checkOutput("MemRead", 32'(mem_bus.MemRead), 32'(e_mr));
            checkOutput("MemWrite", 32'(mem_bus.MemWrite), 32'(e_mw));
            if (acc_now) begin
                checkOutput("mem_a", 32'(mem_bus.mem_a), 32'(t_addr));
                checkOutput("mem_funct3", 32'(mem_bus.mem_funct3), 32'(t_f3));
                if (t_we) checkOutput("mem_wd", mem_bus.mem_wd, t_wd);
            end
            if (t_valid) begin
                if (acc_now) begin
                    if (t_we) begin
                        gold[t_addr] = t_wd[7:0];
                        if (t_f3[1:0] != 2'b00) gold[(int'(t_addr) + 1) % 512] = t_wd[15:8];
                        if (t_f3[1:0] == 2'b10) begin
                            gold[(int'(t_addr) + 2) % 512] = t_wd[23:16];
                            gold[(int'(t_addr) + 3) % 512] = t_wd[31:24];
                        end
                    end else begin
                        t_data = ld_ext(t_f3, {gold[(int'(t_addr) + 3) % 512], gold[(int'(t_addr) + 2) % 512],
                                               gold[(int'(t_addr) + 1) % 512], gold[t_addr]});
                    end
                end
                if (t_age == t_resp_age) t_valid = 0;
                else t_age++;
            end else if (e_gnt != 0) begin
                t_valid = 1; t_age = 1; t_idx = w; m_last = w;
                t_we = f_we[w]; t_addr = f_addr[w]; t_wd = f_wdata[w]; t_f3 = f_funct3[w];
                t_err = (t_f3[1:0] == 2'b10 && t_addr[1:0] != 2'b00) || (t_f3[1:0] == 2'b01 && t_addr[0]);
                t_resp_age = t_err ? 1 : 2;
                t_data = 0;
            end
        end
    end

    task automatic applyStimulus(input int idx, input bit we, input logic [8:0] addr, input logic [31:0] wd,
                                 input logic [2:0] f3, output logic [31:0] got_data, output logic got_err,
                                 output int lat);
        bit seen;
        @(posedge clk); #1;
        f_we[idx] = we; f_addr[idx] = addr; f_wdata[idx] = wd; f_funct3[idx] = f3; f_req[idx] = 1'b1;
        seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (((int'(gnt) >> idx) & 1) == 1) seen = 1;
        end
        checkOutput("gnt_seen", 32'(seen), 1);
        @(posedge clk); #1;
        f_req[idx] = 1'b0;
        seen = 0; lat = 1; got_data = 0; got_err = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (((int'(rvalid) >> idx) & 1) == 1) begin
                seen = 1; got_data = rdata; got_err = rerr;
            end else begin
                lat++;
            end
        end
        checkOutput("rvalid_seen", 32'(seen), 1);
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] d;
        logic        e;
        int          lat, rv_cnt;
        bit          seen;
        int          order[$];
        for (int i = 0; i < N; i++) begin
            f_req[i] = 0; f_we[i] = 0; f_addr[i] = 0; f_wdata[i] = 0; f_funct3[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_gnt", 32'(gnt), 0);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_MemRead", 32'(mem_bus.MemRead), 0);
        #2 rst_n = 1'b1;

        $display("[TB] single load");
        applyStimulus(0, 1'b0, 9'h010, 32'h0, F3_LW, d, e, lat);
        checkOutput("lw_data", d, 32'h8899AABB);
        checkOutput("lw_err", 32'(e), 0);
        checkOutput("lw_latency", 32'(lat), 2);

        $display("[TB] store then load");
        applyStimulus(1, 1'b1, 9'h013, 32'h5A, F3_SB, d, e, lat);
        checkOutput("sb_data", d, 32'h0);
        checkOutput("sb_latency", 32'(lat), 2);
        applyStimulus(1, 1'b0, 9'h013, 32'h0, F3_LBU, d, e, lat);
        checkOutput("lbu_data", d, 32'h0000005A);
        applyStimulus(0, 1'b0, 9'h010, 32'h0, F3_LB, d, e, lat);
        checkOutput("lb_data", d, 32'hFFFFFFBB);
        applyStimulus(1, 1'b0, 9'h010, 32'h0, F3_LW, d, e, lat);
        checkOutput("lw2_data", d, 32'h5A99AABB);

        $display("[TB] contention");
        @(posedge clk); #1;
        f_we[0] = 0; f_addr[0] = 9'h010; f_funct3[0] = F3_LW;
        f_we[1] = 0; f_addr[1] = 9'h013; f_funct3[1] = F3_LBU;
        f_req[0] = 1; f_req[1] = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gnt == 2'b01) order.push_back(0);
            else if (gnt == 2'b10) order.push_back(1);
            else if (gnt != 2'b00) order.push_back(9);
        end
        @(posedge clk); #1;
        f_req[0] = 0; f_req[1] = 0;
        checkOutput("cont_count", 32'(order.size()), 4);
        for (int k = 0; k < 4 && k < order.size(); k++) checkOutput("cont_order", 32'(order[k]), 32'(k % 2));
        checkOutput("cont_last_rdata", rdata, 32'h0000005A);

        $display("[TB] misaligned");
        applyStimulus(0, 1'b0, 9'h012, 32'h0, F3_LW, d, e, lat);
        checkOutput("mis_lw_err", 32'(e), 1);
        checkOutput("mis_lw_data", d, 32'h0);
        checkOutput("mis_lw_latency", 32'(lat), 1);
        applyStimulus(0, 1'b1, 9'h011, 32'h1234, F3_SH, d, e, lat);
        checkOutput("mis_sh_err", 32'(e), 1);
        checkOutput("mis_sh_latency", 32'(lat), 1);
        applyStimulus(0, 1'b0, 9'h012, 32'h0, 3'b001, d, e, lat);
        checkOutput("lh_after_mis", d, 32'h00005A99);

        $display("[TB] reset mid-transaction");
        @(posedge clk); #1;
        f_we[0] = 1; f_addr[0] = 9'h020; f_wdata[0] = 32'hDEADBEEF; f_funct3[0] = F3_SW; f_req[0] = 1;
        seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (gnt == 2'b01) seen = 1;
        end
        checkOutput("sw_gnt_seen", 32'(seen), 1);
        @(posedge clk); #2;
        rst_n = 1'b0; f_req[0] = 0;
        #1;
        checkOutput("async_MemWrite", 32'(mem_bus.MemWrite), 0);
        checkOutput("async_gnt", 32'(gnt), 0);
        checkOutput("async_rdata", rdata, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        rv_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rvalid != 0) rv_cnt++;
        end
        checkOutput("no_rvalid_after_rst", 32'(rv_cnt), 0);
        @(posedge clk); #1;
        f_we[0] = 0; f_addr[0] = 9'h020; f_funct3[0] = F3_LW;
        f_we[1] = 0; f_addr[1] = 9'h010; f_funct3[1] = F3_LW;
        f_req[0] = 1; f_req[1] = 1;
        seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (gnt != 0) begin
                seen = 1;
                checkOutput("post_rst_first_gnt", 32'(gnt), 32'h1);
            end
        end
        checkOutput("post_rst_gnt_seen", 32'(seen), 1);
        @(posedge clk); #1;
        f_req[0] = 0; f_req[1] = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (rvalid != 0) begin
                seen = 1;
                checkOutput("post_rst_rvalid", 32'(rvalid), 32'h1);
                checkOutput("dropped_sw_not_written", rdata, 32'h0);
            end
        end
        checkOutput("post_rst_rvalid_seen", 32'(seen), 1);

        $display("[TB] idle hold");
        applyStimulus(1, 1'b0, 9'h010, 32'h0, F3_LW, d, e, lat);
        checkOutput("pre_idle_data", d, 32'h5A99AABB);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("idle_strobes", {28'b0, gnt, rvalid} | {30'b0, mem_bus.MemRead, mem_bus.MemWrite}, 0);
            checkOutput("idle_rdata_hold", rdata, 32'h5A99AABB);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (MemRead/MemWrite/a/wd/Funct3/rd) between NUM_REQ requesters, e.g. core load/store unit and a debug/DMA loader.
- Arbitrates round-robin and runs one memory transaction at a time through a 3-state FSM.
- Returns read data with a valid pulse.
- Rejects misaligned accesses with an error response; a rejected access never touches memory.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DM_ADDRESS, 9, data-memory address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; memory samples on its falling edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held until gnt.
- req_we  in  NUM_REQ  1 = store, 0 = load.
- req_addr  in  NUM_REQ*DM_ADDRESS  packed byte addresses.
- req_wdata  in  NUM_REQ*DATA_W  packed store data.
- req_funct3  in  NUM_REQ*3  packed RISC-V funct3 (LB/LH/LW/LBU/SB/SH/SW).
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse; request fields latched this cycle.
- rvalid  out  NUM_REQ  one-hot, 1-cycle response pulse, for loads and stores.
- rdata  out  DATA_W  load data, valid with rvalid; 0 for stores and errors.
- rerr  out  1  misalignment error, valid with rvalid.
- MemRead  out  1  to data memory.
- MemWrite  out  1  to data memory.
- mem_a  out  DM_ADDRESS  to data memory.
- mem_wd  out  DATA_W  to data memory.
- mem_funct3  out  3  to data memory.
- mem_rd  in  DATA_W  from data memory; combinationally valid during ACCESS.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt=0, rvalid=0, rdata=0, rerr=0; MemRead=MemWrite=0; mem_a=0, mem_wd=0, mem_funct3=0; last_winner=NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction drops the transaction. No rvalid is issued afterwards; the requester already holds gnt and must re-issue.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req: winner = first requester after last_winner, wrapping modulo NUM_REQ.
  - gnt[winner]=1 combinationally this cycle; latch we/addr/wdata/funct3/winner; update last_winner.
  - Aligned access -> ACCESS. Misaligned -> RESP with err flag.
  - No req: stay in IDLE, gnt=0.
- Misaligned means:
  - funct3[1:0]=10 (LW/SW) with addr[1:0]!=0;
  - funct3[1:0]=01 (LH/LHU/SH) with addr[0]!=0.
  - Byte accesses are never misaligned.
- ACCESS (exactly 1 cycle):
  - MemRead=~we, MemWrite=we; mem_a, mem_wd, mem_funct3 driven from the latch. All memory outputs come from registers, so they are glitch-free.
  - End of cycle: rdata_reg <= we ? 0 : mem_rd. -> RESP.
- RESP (exactly 1 cycle):
  - MemRead=MemWrite=0; rvalid[winner]=1; rdata=rdata_reg; rerr=err flag.
  - -> IDLE. No request is accepted in RESP.
- Timing:
  - Latency gnt -> rvalid is 2 cycles (1 cycle on the error path).
  - Peak throughput is 1 access per 3 cycles.
- Outside RESP: rvalid=0, rerr=0; rdata holds its last value.
- Simultaneous requests: exactly one gnt per grant cycle. Losers keep req high and are served in rotation, so with NUM_REQ requesters the maximum wait is NUM_REQ-1 transactions.
- A req deasserted before gnt is ignored; there is no commitment before gnt.
- req seen during ACCESS/RESP is not granted until the next IDLE.
- Memory address wrap is the memory's concern: addresses pass through unmodified.

Decomposition:
- Package dmem_arb_pkg:
  - state_t enum {IDLE, ACCESS, RESP};
  - funct3 localparams F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_SB=000, F3_SH=001, F3_SW=010;
  - function is_misaligned(funct3, addr[1:0]).
- Sub-module rr_arbiter #(N): inputs req, last; output one-hot grant. Purely combinational rotate-priority. Instantiated once.

Test Plan:
- Single load: preload word 0x8899AABB at addr 0x010. Requester 0 issues LW at 0x010 -> gnt[0] in cycle T, MemRead=1 in T+1, rvalid[0] in T+2 with rdata=0x8899AABB, rerr=0.
- Store then load: requester 1 SB 0x5A at 0x013, then LBU 0x013 -> MemWrite=1 one cycle; second rvalid[1] with rdata=0x0000005A.
- Contention: both req high continuously after reset -> gnt order 0,1,0,1; each rvalid matches the preceding gnt index; gnt never two-hot.
- Misaligned: requester 0 LW at 0x012 -> gnt[0], no MemRead/MemWrite in any cycle, rvalid[0] next cycle, rerr=1, rdata=0. SH at 0x011 -> same behaviour.
- Reset mid-op: assert rst_n=0 during ACCESS of a SW -> outputs zero immediately (async). After release: no rvalid, state IDLE, next grant goes to requester 0.
- Idle hold: no req for 10 cycles -> gnt, rvalid, MemRead, MemWrite stay 0; rdata holds its previous value.
